prog_event_counter: RTL and testbench
=====================================

Name: prog_event_counter

Overview:
- Parametrised, programmable successor to the team's free-running enable counter.
- Counts prescaled enable ticks in one of four modes: free-run wrap, auto-reload, one-shot, or down-count.
- Adds a programmable terminal count, synchronous load/clear, value capture, and single-cycle event pulses.
- Used as the general timer/event-count block wherever a bare up-counter was previously instantiated.

Parameters:
- WIDTH, 23, counter width in bits.
- PRESCALE_W, 8, width of the prescale divider value.
- CLR_ON_DIS, 1: counts and prescaler cleared while en=0 (legacy behaviour). 0: values held while en=0.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  count enable.
- clr  input  1  synchronous clear of count, prescaler and done.
- load  input  1  load load_val into count.
- load_val  input  WIDTH  value for load.
- tc_val  input  WIDTH  terminal count / reload value.
- mode  input  2  00 FREE, 01 RELOAD, 10 ONESHOT, 11 DOWN.
- prescale  input  PRESCALE_W  tick every prescale+1 enabled cycles.
- capture  input  1  snapshot request.
- counts  output  WIDTH  current count.
- cap_val  output  WIDTH  last captured count.
- tc_pulse  output  1  one-cycle terminal-count event.
- wrap_pulse  output  1  one-cycle FREE-mode rollover event.
- done  output  1  ONESHOT complete, sticky.

Behaviour:
- Reset values: counts=0, cap_val=0, tc_pulse=0, wrap_pulse=0, done=0, prescaler=0.
- Control priority per cycle: rst > clr > load > (en low) > tick.
  - capture is evaluated independently of that chain.
- Prescaler:
  - Increments each cycle with en=1.
  - When it equals prescale, it asserts an internal tick that cycle and returns to 0.
  - prescale=0 gives a tick every enabled cycle.
  - A prescale change takes effect at the next compare.
  - If prescale is lowered below the current prescaler value, the prescaler wraps through 2^PRESCALE_W.
- en=0:
  - Prescaler is cleared.
  - CLR_ON_DIS=1: counts<=0 and done<=0.
  - CLR_ON_DIS=0: counts and done are held.
  - No pulses are generated.
- clr: counts<=0, prescaler<=0, done<=0; pulses are 0 that cycle.
- load: counts<=load_val, done<=0, prescaler<=0; no tick is processed that cycle.
- Tick actions by mode (terminal comparison uses the pre-update counts):
  - FREE: counts<=counts+1, modulo 2^WIDTH. tc_pulse when counts==tc_val. wrap_pulse when counts is all-ones.
  - RELOAD: if counts==tc_val, counts<=0 and tc_pulse; otherwise +1.
  - ONESHOT: if done, hold. Else if counts==tc_val, hold, done<=1 and tc_pulse (once only). Else +1.
  - DOWN: if counts==0, counts<=tc_val and tc_pulse; otherwise -1.
- RELOAD/ONESHOT with counts > tc_val (after load or a tc_val change):
  - Count runs up and wraps through 2^WIDTH to reach tc_val.
  - No wrap_pulse is generated in these modes.
- Pulse timing: pulses are registered and high exactly one cycle, the cycle after the tick.
- Latency: counts updates one cycle after the tick cycle.
- Mode change:
  - Takes effect on the next tick; counts is not modified.
  - done is cleared when mode != ONESHOT.
- capture:
  - cap_val<=counts (pre-update value) in the cycle capture=1.
  - Valid even when clr or load is active; the old value is captured.
  - rst overrides capture.
- tc_val change mid-run: compared at the next tick; no retroactive pulse.
- Reset mid-operation: all state returns to reset values the next cycle, regardless of other inputs.

Decomposition:
- Package prog_counter_pkg:
  - Mode localparams MODE_FREE=2'b00, MODE_RELOAD=2'b01, MODE_ONESHOT=2'b10, MODE_DOWN=2'b11.
  - Default width constants.
- Sub-module counter_prescaler:
  - Params: PRESCALE_W.
  - Ports: clk, rst, clr, en, prescale, tick.
  - clr input is driven by clr|load.
- Top module holds the mode datapath, capture and pulse registers.

Test Plan:
- Reset and legacy mode:
  - Stimulus: rst pulse, then en=1, mode=FREE, prescale=0, tc_val=5 for 7 cycles, then en=0.
  - Response: counts 0,1..7; tc_pulse one cycle after counts==5; counts=0 one cycle after en falls (CLR_ON_DIS=1).
- Prescale and RELOAD:
  - Stimulus: prescale=2, mode=RELOAD, tc_val=3.
  - Response: counts steps every 3 cycles 0,1,2,3,0; tc_pulse once per 12 cycles.
- ONESHOT:
  - Stimulus: tc_val=4.
  - Response: counts stops at 4; done=1; exactly one tc_pulse; further ticks leave counts=4.
  - Then load with load_val=1: done=0 and counting resumes from 1.
- DOWN with load:
  - Stimulus: load_val=3, tc_val=2.
  - Response: counts 3,2,1,0,2,1,0; tc_pulse after each 0 reload.
- FREE wrap (WIDTH=4 build):
  - Stimulus: run counts through 15.
  - Response: 15->0 with wrap_pulse high for one cycle.
- Simultaneous events:
  - Stimulus: capture+load same cycle at counts=9, load_val=20.
  - Response: cap_val=9, counts=20.
  - Then rst together with capture: cap_val=0, counts=0.

Source files
------------

// File: rtl/prog_counter_pkg.sv
// prog_counter_pkg: shared constants for the programmable event counter.
// Exports the mode encodings and the default width parameters used by
// prog_event_counter and counter_prescaler.
package prog_counter_pkg;

  localparam logic [1:0] MODE_FREE    = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_DOWN    = 2'b11;

  localparam int DEFAULT_WIDTH      = 23;
  localparam int DEFAULT_PRESCALE_W = 8;

endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: divides enabled cycles down to a single-cycle tick.
// Ports: clk/rst (sync, active-high), clr (clear divider), en (advance),
//        prescale (tick every prescale+1 enabled cycles), tick (combinational).
module counter_prescaler
  import prog_counter_pkg::*;
#(
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] PSC_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] psc_q, psc_d;

  // Equality compare only: if prescale drops below the running value the
  // divider keeps counting and rolls through 2^PRESCALE_W before matching.
  always_comb begin
    tick  = 1'b0;
    psc_d = psc_q;
    if (clr || !en) begin
      psc_d = '0;
    end else if (psc_q == prescale) begin
      tick  = 1'b1;
      psc_d = '0;
    end else begin
      psc_d = psc_q + PSC_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) psc_q <= '0;
    else     psc_q <= psc_d;
  end

endmodule

// File: rtl/prog_event_counter.sv
// prog_event_counter: prescaled event counter with FREE/RELOAD/ONESHOT/DOWN modes.
// Ports: clk/rst (sync, active-high); en, clr, load/load_val, tc_val, mode,
//        prescale, capture in; counts, cap_val, tc_pulse, wrap_pulse, done out.
module prog_event_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W,
  parameter bit CLR_ON_DIS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      tc_val,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  capture,
  output logic [WIDTH-1:0]      counts,
  output logic [WIDTH-1:0]      cap_val,
  output logic                  tc_pulse,
  output logic                  wrap_pulse,
  output logic                  done
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             tick;
  logic [WIDTH-1:0] counts_q, counts_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic             tc_q, tc_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             at_tc;

  // load also restarts the divider so the first tick after a load is a full period.
  counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr | load),
    .en       (en),
    .prescale (prescale),
    .tick     (tick)
  );

  assign at_tc = (counts_q == tc_val);

  always_comb begin
    counts_d = counts_q;
    done_d   = done_q;
    tc_d     = 1'b0;
    wrap_d   = 1'b0;
    // Capture sits outside the control chain and always sees the pre-update count.
    cap_d    = capture ? counts_q : cap_q;

    if (clr) begin
      counts_d = '0;
      done_d   = 1'b0;
    end else if (load) begin
      counts_d = load_val;
      done_d   = 1'b0;
    end else if (!en) begin
      if (CLR_ON_DIS) begin
        counts_d = '0;
        done_d   = 1'b0;
      end
    end else if (tick) begin
      unique case (mode)
        MODE_FREE: begin
          counts_d = counts_q + CNT_ONE;
          tc_d     = at_tc;
          wrap_d   = &counts_q;
        end
        MODE_RELOAD: begin
          if (at_tc) begin
            counts_d = '0;
            tc_d     = 1'b1;
          end else begin
            counts_d = counts_q + CNT_ONE;
          end
        end
        MODE_ONESHOT: begin
          if (!done_q) begin
            if (at_tc) begin
              done_d = 1'b1;
              tc_d   = 1'b1;
            end else begin
              counts_d = counts_q + CNT_ONE;
            end
          end
        end
        default: begin  // MODE_DOWN
          if (counts_q == '0) begin
            counts_d = tc_val;
            tc_d     = 1'b1;
          end else begin
            counts_d = counts_q - CNT_ONE;
          end
        end
      endcase
    end

    // done only has meaning in ONESHOT; leaving that mode drops it.
    if (mode != MODE_ONESHOT) done_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counts_q <= '0;
      cap_q    <= '0;
      tc_q     <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      counts_q <= counts_d;
      cap_q    <= cap_d;
      tc_q     <= tc_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
    end
  end

  assign counts     = counts_q;
  assign cap_val    = cap_q;
  assign tc_pulse   = tc_q;
  assign wrap_pulse = wrap_q;
  assign done       = done_q;

endmodule

// File: tb/tb_prog_event_counter.sv
module tb_prog_event_counter;

  logic        clk = 1'b0;
  logic        rst, en, clr, load, capture;
  logic [22:0] load_val, tc_val;
  logic [1:0]  mode;
  logic [7:0]  prescale;

  logic [22:0] c0, cap0;
  logic        tc0, wr0, dn0;
  logic [3:0]  c1, cap1;
  logic        tc1, wr1, dn1;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Default build: 23-bit, legacy clear on disable.
  prog_event_counter #(.WIDTH(23), .PRESCALE_W(8), .CLR_ON_DIS(1'b1)) dut0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .tc_val(tc_val), .mode(mode), .prescale(prescale),
    .capture(capture), .counts(c0), .cap_val(cap0), .tc_pulse(tc0),
    .wrap_pulse(wr0), .done(dn0));

  // Narrow build that holds its state while disabled.
  prog_event_counter #(.WIDTH(4), .PRESCALE_W(8), .CLR_ON_DIS(1'b0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .tc_val(tc_val[3:0]), .mode(mode), .prescale(prescale),
    .capture(capture), .counts(c1), .cap_val(cap1), .tc_pulse(tc1),
    .wrap_pulse(wr1), .done(dn1));

  typedef struct {
    longint cnt;
    longint cap;
    bit     tc;
    bit     wrap;
    bit     done;
    int     psc;
  } mstate_t;

  mstate_t m0, m1;

  // Next-state of the counter as described by its behavioural rules.
  function automatic mstate_t step(mstate_t s, int w, bit clr_on_dis);
    mstate_t n;
    longint  mask = (longint'(1) << w) - 1;
    longint  tcv  = longint'(tc_val) & mask;
    bit      tk;
    n = s;
    n.tc = 0;
    n.wrap = 0;
    if (rst) begin
      n.cnt = 0; n.cap = 0; n.done = 0; n.psc = 0;
      return n;
    end
    if (capture) n.cap = s.cnt;
    if (clr) begin
      n.cnt = 0; n.done = 0; n.psc = 0;
    end else if (load) begin
      n.cnt = longint'(load_val) & mask; n.done = 0; n.psc = 0;
    end else if (!en) begin
      n.psc = 0;
      if (clr_on_dis) begin n.cnt = 0; n.done = 0; end
    end else begin
      tk = (s.psc == int'(prescale));
      n.psc = tk ? 0 : (s.psc + 1) % 256;
      if (tk) begin
        case (mode)
          2'b00: begin
            n.tc = (s.cnt == tcv);
            n.wrap = (s.cnt == mask);
            n.cnt = (s.cnt + 1) & mask;
          end
          2'b01: begin
            if (s.cnt == tcv) begin n.cnt = 0; n.tc = 1; end
            else n.cnt = (s.cnt + 1) & mask;
          end
          2'b10: begin
            if (!s.done) begin
              if (s.cnt == tcv) begin n.done = 1; n.tc = 1; end
              else n.cnt = (s.cnt + 1) & mask;
            end
          end
          default: begin
            if (s.cnt == 0) begin n.cnt = tcv; n.tc = 1; end
            else n.cnt = (s.cnt - 1) & mask;
          end
        endcase
      end
    end
    if (mode != 2'b10) n.done = 0;
    return n;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock: predict, advance, then compare both instances against the model.
  task automatic cyc();
    mstate_t n0, n1;
    n0 = step(m0, 23, 1'b1);
    n1 = step(m1, 4, 1'b0);
    @(posedge clk);
    #1;
    m0 = n0;
    m1 = n1;
    chk("d0_counts", longint'(c0), m0.cnt);
    chk("d0_cap", longint'(cap0), m0.cap);
    chk("d0_tc", longint'(tc0), longint'(m0.tc));
    chk("d0_wrap", longint'(wr0), longint'(m0.wrap));
    chk("d0_done", longint'(dn0), longint'(m0.done));
    chk("d1_counts", longint'(c1), m1.cnt);
    chk("d1_cap", longint'(cap1), m1.cap);
    chk("d1_tc", longint'(tc1), longint'(m1.tc));
    chk("d1_wrap", longint'(wr1), longint'(m1.wrap));
    chk("d1_done", longint'(dn1), longint'(m1.done));
  endtask

  int pulses;
  int down_exp [6] = '{2, 1, 0, 2, 1, 0};

  initial begin
    m0 = '{default: 0};
    m1 = '{default: 0};
    rst = 1; en = 0; clr = 0; load = 0; capture = 0;
    load_val = 0; tc_val = 0; mode = 2'b00; prescale = 0;
    cyc(); cyc();
    chk("reset_counts", longint'(c0), 0);
    chk("reset_done", longint'(dn0), 0);

    // Legacy FREE run with prescale 0.
    rst = 0; en = 1; mode = 2'b00; prescale = 0; tc_val = 5;
    for (int i = 1; i <= 7; i++) begin
      cyc();
      chk("free_step", longint'(c0), i);
      chk("free_tc_lit", longint'(tc0), (i == 6) ? 1 : 0);
    end
    en = 0;
    cyc();
    chk("dis_clear", longint'(c0), 0);
    chk("dis_hold", longint'(c1), 7);

    // Prescale 2, RELOAD at 3: one pulse per 12 cycles.
    prescale = 2; mode = 2'b01; tc_val = 3; en = 1;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      pulses += int'(tc0);
      if (i % 3 == 0) chk("reload_step", longint'(c0), (i / 3) % 4);
    end
    chk("reload_pulses", pulses, 1);

    // ONESHOT at 4.
    clr = 1; cyc(); clr = 0;
    mode = 2'b10; prescale = 0; tc_val = 4;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin cyc(); pulses += int'(tc0); end
    chk("oneshot_pulses", pulses, 1);
    chk("oneshot_hold", longint'(c0), 4);
    chk("oneshot_done", longint'(dn0), 1);
    load = 1; load_val = 1; cyc(); load = 0;
    chk("oneshot_reload", longint'(c0), 1);
    chk("oneshot_undone", longint'(dn0), 0);
    cyc();
    chk("oneshot_resume", longint'(c0), 2);

    // DOWN from a load of 3, reloading to 2.
    mode = 2'b11; tc_val = 2; load_val = 3; load = 1; cyc(); load = 0;
    chk("down_load", longint'(c0), 3);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("down_seq", longint'(c0), down_exp[i]);
      chk("down_tc_lit", longint'(tc0), (i == 3) ? 1 : 0);
    end

    // FREE rollover on both widths via a load near all-ones.
    mode = 2'b00; load_val = 23'h7FFFFD; load = 1; cyc(); load = 0;
    cyc(); cyc(); cyc();
    chk("wrap_cnt0", longint'(c0), 0);
    chk("wrap_pulse0", longint'(wr0), 1);
    chk("wrap_cnt1", longint'(c1), 0);
    chk("wrap_pulse1", longint'(wr1), 1);
    cyc();
    chk("wrap_once", longint'(wr0), 0);

    // capture together with load, then capture together with rst.
    load_val = 9; load = 1; cyc();
    capture = 1; load_val = 20; cyc();
    chk("cap_with_load", longint'(cap0), 9);
    chk("load_with_cap", longint'(c0), 20);
    rst = 1; load = 0; cyc();
    chk("cap_rst", longint'(cap0), 0);
    chk("cnt_rst", longint'(c0), 0);
    rst = 0; capture = 0;

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      clr     = ($urandom_range(0, 59) == 0);
      load    = ($urandom_range(0, 39) == 0);
      en      = ($urandom_range(0, 9) != 0);
      capture = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) prescale = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0)
        tc_val = ($urandom_range(0, 3) == 0) ? 23'($urandom) : 23'($urandom_range(0, 20));
      load_val = ($urandom_range(0, 1) == 0) ? 23'($urandom_range(0, 20))
                                             : 23'h7FFFFF - 23'($urandom_range(0, 5));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
